// File: rtl/iob_plic_arbiter.sv
// Round-robin arbiter sharing the PLIC IOb register port among N_MASTERS requesters.
// Define IOB_PLIC_ARB_TIMEOUT_EN to add a read-response timeout with a sticky err_o.
module iob_plic_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 15
) (
  input  logic                           clk_i,
  input  logic                           arst_n_i,
  input  logic                           cke_i,
  input  logic [N_MASTERS-1:0]           m_avalid_i,
  input  logic [N_MASTERS*ADDR_W-1:0]    m_addr_i,
  input  logic [N_MASTERS*DATA_W-1:0]    m_wdata_i,
  input  logic [N_MASTERS*DATA_W/8-1:0]  m_wstrb_i,
  output logic [N_MASTERS-1:0]           m_ready_o,
  output logic [N_MASTERS-1:0]           m_rvalid_o,
  output logic [DATA_W-1:0]              m_rdata_o,
  output logic                           s_avalid_o,
  output logic [ADDR_W-1:0]              s_addr_o,
  output logic [DATA_W-1:0]              s_wdata_o,
  output logic [DATA_W/8-1:0]            s_wstrb_o,
  input  logic                           s_ready_i,
  input  logic                           s_rvalid_i,
  input  logic [DATA_W-1:0]              s_rdata_i
`ifdef IOB_PLIC_ARB_TIMEOUT_EN
  ,
  output logic                           err_o
`endif
);

  localparam int GW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int SW = DATA_W / 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [GW-1:0] pick;

  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [SW-1:0]     g_wstrb;

`ifdef IOB_PLIC_ARB_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  assign err_o = err_q;
`endif

  // Scan downward so the master closest after last_q is the one left in pick.
  always_comb begin
    pick = last_q;
    for (int i = N_MASTERS; i >= 1; i--) begin
      int idx;
      idx = (int'(last_q) + i) % N_MASTERS;
      if (m_avalid_i[idx]) pick = GW'(idx);
    end
  end

  assign g_addr  = m_addr_i[int'(grant_q)*ADDR_W +: ADDR_W];
  assign g_wdata = m_wdata_i[int'(grant_q)*DATA_W +: DATA_W];
  assign g_wstrb = m_wstrb_i[int'(grant_q)*SW +: SW];

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    m_ready_o  = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    s_avalid_o = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_wstrb_o  = '0;
`ifdef IOB_PLIC_ARB_TIMEOUT_EN
    cnt_d = (state_q == RESP) ? cnt_q + 1'b1 : '0;
    err_d = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|m_avalid_i) begin
          grant_d = pick;
          state_d = REQ;
        end
      end
      REQ: begin
        s_avalid_o = 1'b1;
        s_addr_o   = g_addr;
        s_wdata_o  = g_wdata;
        s_wstrb_o  = g_wstrb;
        // Handshakes to masters only fire on enabled cycles, when the FSM actually advances.
        if (s_ready_i && cke_i) begin
          m_ready_o[grant_q] = 1'b1;
          last_d             = grant_q;
          state_d            = (|g_wstrb) ? IDLE : RESP;
        end
      end
      RESP: begin
        if (s_rvalid_i && cke_i) begin
          m_rvalid_o[grant_q] = 1'b1;
          m_rdata_o           = s_rdata_i;
          state_d             = IDLE;
        end
`ifdef IOB_PLIC_ARB_TIMEOUT_EN
        else if (cke_i && cnt_q == CW'(TIMEOUT)) begin
          m_rvalid_o[grant_q] = 1'b1;
          m_rdata_o           = '1;
          err_d               = 1'b1;
          state_d             = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(N_MASTERS - 1);
`ifdef IOB_PLIC_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else if (cke_i) begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
`ifdef IOB_PLIC_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_iob_plic_arbiter.sv
// Directed bench for iob_plic_arbiter (2 masters); covers the timeout path when
// IOB_PLIC_ARB_TIMEOUT_EN is defined.
module tb_iob_plic_arbiter;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic        cke_i;
  logic [1:0]  m_avalid_i;
  logic [31:0] m_addr_i;
  logic [63:0] m_wdata_i;
  logic [7:0]  m_wstrb_i;
  logic [1:0]  m_ready_o;
  logic [1:0]  m_rvalid_o;
  logic [31:0] m_rdata_o;
  logic        s_avalid_o;
  logic [15:0] s_addr_o;
  logic [31:0] s_wdata_o;
  logic [3:0]  s_wstrb_o;
  logic        s_ready_i;
  logic        s_rvalid_i;
  logic [31:0] s_rdata_i;
`ifdef IOB_PLIC_ARB_TIMEOUT_EN
  logic        err_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  iob_plic_arbiter #(.N_MASTERS(2), .ADDR_W(16), .DATA_W(32), .TIMEOUT(15)) dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .cke_i      (cke_i),
    .m_avalid_i (m_avalid_i),
    .m_addr_i   (m_addr_i),
    .m_wdata_i  (m_wdata_i),
    .m_wstrb_i  (m_wstrb_i),
    .m_ready_o  (m_ready_o),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .s_avalid_o (s_avalid_o),
    .s_addr_o   (s_addr_o),
    .s_wdata_o  (s_wdata_o),
    .s_wstrb_o  (s_wstrb_o),
    .s_ready_i  (s_ready_i),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i)
`ifdef IOB_PLIC_ARB_TIMEOUT_EN
    ,
    .err_o      (err_o)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_m(input int k, input logic v, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    m_avalid_i[k]       = v;
    m_addr_i[k*16 +: 16] = a;
    m_wdata_i[k*32 +: 32] = d;
    m_wstrb_i[k*4 +: 4]  = s;
  endtask

  initial begin
    arst_n_i   = 1'b0;
    cke_i      = 1'b1;
    m_avalid_i = '0;
    m_addr_i   = '0;
    m_wdata_i  = '0;
    m_wstrb_i  = '0;
    s_ready_i  = 1'b0;
    s_rvalid_i = 1'b0;
    s_rdata_i  = '0;

    // Reset state
    @(negedge clk_i);
    check("rst_s_avalid", s_avalid_o, 0);
    check("rst_m_ready", m_ready_o, 0);
    check("rst_m_rvalid", m_rvalid_o, 0);
    check("rst_m_rdata", m_rdata_o, 0);
    check("rst_s_addr", s_addr_o, 0);
`ifdef IOB_PLIC_ARB_TIMEOUT_EN
    check("rst_err", err_o, 0);
`endif
    step();
    arst_n_i = 1'b1;

    // Single write from m0
    s_ready_i = 1'b1;
    set_m(0, 1'b1, 16'h0004, 32'h3, 4'hF);
    @(negedge clk_i);
    check("wr_idle_s_avalid", s_avalid_o, 0);
    step();
    @(negedge clk_i);
    check("wr_req_s_avalid", s_avalid_o, 1);
    check("wr_req_s_addr", s_addr_o, 16'h0004);
    check("wr_req_s_wdata", s_wdata_o, 32'h3);
    check("wr_req_s_wstrb", s_wstrb_o, 4'hF);
    check("wr_req_m_ready", m_ready_o, 2'b01);
    step();
    set_m(0, 1'b0, 16'h0004, 32'h3, 4'hF);
    @(negedge clk_i);
    check("wr_done_s_avalid", s_avalid_o, 0);
    check("wr_done_m_ready", m_ready_o, 0);
    check("wr_done_m_rvalid", m_rvalid_o, 0);

    // Single read from m1
    set_m(1, 1'b1, 16'h2000, 32'h0, 4'h0);
    step();
    @(negedge clk_i);
    check("rd_req_m_ready", m_ready_o, 2'b10);
    check("rd_req_s_addr", s_addr_o, 16'h2000);
    check("rd_req_s_wstrb", s_wstrb_o, 0);
    step();
    set_m(1, 1'b0, 16'h2000, 32'h0, 4'h0);
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h0000_0005;
    @(negedge clk_i);
    check("rd_resp_s_avalid", s_avalid_o, 0);
    check("rd_resp_m_rvalid", m_rvalid_o, 2'b10);
    check("rd_resp_m_rdata", m_rdata_o, 32'h5);
    step();
    s_rvalid_i = 1'b0;
    @(negedge clk_i);
    check("rd_after_m_rvalid", m_rvalid_o, 0);
    check("rd_after_m_rdata", m_rdata_o, 0);
    step();
    s_rvalid_i = 1'b1;
    @(negedge clk_i);
    check("idle_stray_rvalid", m_rvalid_o, 0);
    check("idle_stray_rdata", m_rdata_o, 0);
    s_rvalid_i = 1'b0;

    // Contention from reset: expect 0,1,0,1
    arst_n_i = 1'b0;
    step();
    arst_n_i = 1'b1;
    set_m(0, 1'b1, 16'h0100, 32'h0, 4'h0);
    set_m(1, 1'b1, 16'h0200, 32'h0, 4'h0);
    for (int t = 0; t < 4; t++) begin
      logic [1:0]  exp_g;
      logic [15:0] exp_a;
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_a = (t % 2 == 0) ? 16'h0100 : 16'h0200;
      step();
      @(negedge clk_i);
      check($sformatf("cont%0d_m_ready", t), m_ready_o, exp_g);
      check($sformatf("cont%0d_s_addr", t), s_addr_o, exp_a);
      step();
      s_rvalid_i = 1'b1;
      s_rdata_i  = 32'(t + 16);
      @(negedge clk_i);
      check($sformatf("cont%0d_m_rvalid", t), m_rvalid_o, exp_g);
      check($sformatf("cont%0d_m_rdata", t), m_rdata_o, 32'(t + 16));
      step();
      s_rvalid_i = 1'b0;
    end
    m_avalid_i = '0;

    // Backpressure: grant and address hold while s_ready_i is low
    s_ready_i = 1'b0;
    set_m(0, 1'b1, 16'h0300, 32'h0, 4'h0);
    step();
    set_m(0, 1'b0, 16'h0300, 32'h0, 4'h0);
    set_m(1, 1'b1, 16'h0200, 32'hAB, 4'h3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check($sformatf("bp%0d_s_avalid", i), s_avalid_o, 1);
      check($sformatf("bp%0d_s_addr", i), s_addr_o, 16'h0300);
      check($sformatf("bp%0d_m_ready", i), m_ready_o, 0);
      step();
    end
    s_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_accept_m_ready", m_ready_o, 2'b01);
    check("bp_accept_s_addr", s_addr_o, 16'h0300);
    step();
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h77;
    @(negedge clk_i);
    check("bp_resp_m_rvalid", m_rvalid_o, 2'b01);
    step();
    s_rvalid_i = 1'b0;
    step();
    @(negedge clk_i);
    check("bp_m1_m_ready", m_ready_o, 2'b10);
    check("bp_m1_s_wstrb", s_wstrb_o, 4'h3);
    check("bp_m1_s_wdata", s_wdata_o, 32'hAB);
    step();
    set_m(1, 1'b0, 16'h0200, 32'hAB, 4'h3);
    @(negedge clk_i);
    check("bp_m1_done_s_avalid", s_avalid_o, 0);
    check("bp_m1_done_m_rvalid", m_rvalid_o, 0);

    // Reset in RESP discards the pending response
    set_m(0, 1'b1, 16'h0008, 32'h0, 4'h0);
    step();
    step();
    set_m(0, 1'b0, 16'h0008, 32'h0, 4'h0);
    arst_n_i   = 1'b0;
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk_i);
    check("mid_rst_s_avalid", s_avalid_o, 0);
    check("mid_rst_m_rvalid", m_rvalid_o, 0);
    check("mid_rst_m_rdata", m_rdata_o, 0);
    step();
    arst_n_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_m_rvalid", m_rvalid_o, 0);
    check("post_rst_m_rdata", m_rdata_o, 0);
    step();
    s_rvalid_i = 1'b0;
    set_m(0, 1'b1, 16'h0100, 32'h0, 4'h0);
    set_m(1, 1'b1, 16'h0200, 32'h0, 4'h0);
    step();
    @(negedge clk_i);
    check("post_rst_priority", m_ready_o, 2'b01);
    step();
    m_avalid_i = '0;
    s_rvalid_i = 1'b1;
    step();
    s_rvalid_i = 1'b0;

    // RESP without a response: timeout if enabled, otherwise wait indefinitely
    set_m(0, 1'b1, 16'h0010, 32'h0, 4'h0);
    step();
    step();
    set_m(0, 1'b0, 16'h0010, 32'h0, 4'h0);
`ifdef IOB_PLIC_ARB_TIMEOUT_EN
    for (int k = 0; k < 15; k++) begin
      @(negedge clk_i);
      check($sformatf("to_wait%0d_m_rvalid", k), m_rvalid_o, 0);
      step();
    end
    @(negedge clk_i);
    check("to_fire_m_rvalid", m_rvalid_o, 2'b01);
    check("to_fire_m_rdata", m_rdata_o, 32'hFFFF_FFFF);
    step();
    @(negedge clk_i);
    check("to_after_err", err_o, 1);
    check("to_after_m_rvalid", m_rvalid_o, 0);
    step();
    step();
    @(negedge clk_i);
    check("to_err_sticky", err_o, 1);
`else
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      check($sformatf("resp_wait%0d_m_rvalid", k), m_rvalid_o, 0);
      step();
    end
    s_rvalid_i = 1'b1;
    s_rdata_i  = 32'h1234_5678;
    @(negedge clk_i);
    check("resp_late_m_rvalid", m_rvalid_o, 2'b01);
    check("resp_late_m_rdata", m_rdata_o, 32'h1234_5678);
    step();
    s_rvalid_i = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
